// File: rtl/mac_pkg.sv
// Shared constants, lane vector types, FSM state encoding and drain timing
// for the mac_array front-end.
package mac_pkg;

  localparam int unsigned DEF_MULER_WIDTH  = 8;
  localparam int unsigned DEF_NUM_WIDTH    = 16;
  localparam int unsigned DEF_OUTPUT_WIDTH = 32;
  localparam int unsigned DEF_MULER_DELAY  = 1;
  localparam int unsigned DEF_ROW_SIZE     = 4;
  localparam int unsigned DEF_COLUMN_SIZE  = 4;
  localparam int unsigned DEF_MAX_K        = 16;

  typedef logic [DEF_ROW_SIZE-1:0][DEF_MULER_WIDTH-1:0]    a_vec_t;
  typedef logic [DEF_COLUMN_SIZE-1:0][DEF_MULER_WIDTH-1:0] b_vec_t;
  typedef logic [DEF_ROW_SIZE-1:0][DEF_OUTPUT_WIDTH-1:0]   res_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PROGRAM,
    ST_STREAM,
    ST_DRAIN,
    ST_RESULT
  } feeder_state_e;

  // Cycles from the last streamed beat until result_r is settled.
  function automatic int unsigned drain_cycles(input int unsigned mul_delay,
                                               input int unsigned rows,
                                               input int unsigned cols);
    return mul_delay + rows + cols;
  endfunction

endpackage

// File: rtl/mac_operand_buffer.sv
// MAX_K-deep simple dual-port store of {a,b} operand beats with
// independent write and read pointers.
module mac_operand_buffer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MAX_K  = 16,
  parameter int unsigned PTR_W  = $clog2(MAX_K) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [PTR_W-1:0]  o_wr_ptr,
  output logic [PTR_W-1:0]  o_rd_ptr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned IDX_W = (MAX_K > 1) ? $clog2(MAX_K) : 1;

  logic [DATA_W-1:0] r_mem [MAX_K];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[IDX_W-1:0]];
  assign o_wr_ptr  = r_wr_ptr;
  assign o_rd_ptr  = r_rd_ptr;

endmodule

// File: rtl/mac_array_feeder.sv
// Buffers K operand beats, programs and streams them into mac_array without
// bubbles, then returns the drained result over a valid/ready handshake.
module mac_array_feeder
  import mac_pkg::*;
#(
  parameter int unsigned MULER_WIDTH  = DEF_MULER_WIDTH,
  parameter int unsigned NUM_WIDTH    = DEF_NUM_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int unsigned MULER_DELAY  = DEF_MULER_DELAY,
  parameter int unsigned ROW_SIZE     = DEF_ROW_SIZE,
  parameter int unsigned COLUMN_SIZE  = DEF_COLUMN_SIZE,
  parameter int unsigned MAX_K        = DEF_MAX_K
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cmd_valid,
  output logic                                      cmd_ready,
  input  logic [NUM_WIDTH-1:0]                      cmd_num,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [ROW_SIZE-1:0][MULER_WIDTH-1:0]      in_a,
  input  logic [COLUMN_SIZE-1:0][MULER_WIDTH-1:0]   in_b,
  output logic                                      num_valid,
  output logic [NUM_WIDTH-1:0]                      num,
  output logic [ROW_SIZE-1:0][MULER_WIDTH-1:0]      data_a,
  output logic [COLUMN_SIZE-1:0][MULER_WIDTH-1:0]   data_b,
  input  logic [ROW_SIZE-1:0][OUTPUT_WIDTH-1:0]     result_r,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ROW_SIZE-1:0][OUTPUT_WIDTH-1:0]     out_data,
  output logic                                      out_err
);

  localparam int unsigned A_W          = ROW_SIZE * MULER_WIDTH;
  localparam int unsigned B_W          = COLUMN_SIZE * MULER_WIDTH;
  localparam int unsigned D_W          = A_W + B_W;
  localparam int unsigned PTR_W        = $clog2(MAX_K) + 1;
  localparam int unsigned DRAIN_CYCLES = drain_cycles(MULER_DELAY, ROW_SIZE, COLUMN_SIZE);
  localparam int unsigned DC_W         = $clog2(DRAIN_CYCLES + 1);

  feeder_state_e                            r_state;
  logic [NUM_WIDTH-1:0]                     r_k;
  logic [DC_W-1:0]                          r_drain_cnt;
  logic                                     r_cmd_ready;
  logic                                     r_in_ready;
  logic                                     r_num_valid;
  logic [NUM_WIDTH-1:0]                     r_num;
  logic [ROW_SIZE-1:0][MULER_WIDTH-1:0]     r_data_a;
  logic [COLUMN_SIZE-1:0][MULER_WIDTH-1:0]  r_data_b;
  logic                                     r_out_valid;
  logic [ROW_SIZE-1:0][OUTPUT_WIDTH-1:0]    r_out_data;
  logic                                     r_out_err;

  logic                                     w_wr_en;
  logic                                     w_rd_en;
  logic                                     w_clr;
  logic [PTR_W-1:0]                         w_wr_ptr;
  logic [PTR_W-1:0]                         w_rd_ptr;
  logic [D_W-1:0]                           w_rd_data;
  logic [ROW_SIZE-1:0][MULER_WIDTH-1:0]     w_rd_a;
  logic [COLUMN_SIZE-1:0][MULER_WIDTH-1:0]  w_rd_b;
  logic                                     w_last_load;
  logic                                     w_last_beat;

  assign w_clr       = (r_state == ST_IDLE);
  assign w_wr_en     = (r_state == ST_LOAD) && in_valid && r_in_ready;
  assign w_last_load = (NUM_WIDTH'(w_wr_ptr) + NUM_WIDTH'(1)) == r_k;
  assign w_last_beat = NUM_WIDTH'(w_rd_ptr) == r_k;
  // Beat 0 is fetched during PROGRAM so the stream starts with no bubble.
  assign w_rd_en     = (r_state == ST_PROGRAM) || ((r_state == ST_STREAM) && !w_last_beat);
  assign w_rd_a      = w_rd_data[D_W-1 -: A_W];
  assign w_rd_b      = w_rd_data[B_W-1:0];

  mac_operand_buffer #(
    .DATA_W (D_W),
    .MAX_K  (MAX_K),
    .PTR_W  (PTR_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_wr_en   (w_wr_en),
    .i_wr_data ({in_a, in_b}),
    .i_rd_en   (w_rd_en),
    .o_wr_ptr  (w_wr_ptr),
    .o_rd_ptr  (w_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_drain_cnt <= '0;
      r_cmd_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_num_valid <= 1'b0;
      r_num       <= '0;
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_k         <= cmd_num;
            r_cmd_ready <= 1'b0;
            if (cmd_num == '0) begin
              r_state     <= ST_RESULT;
              r_out_valid <= 1'b1;
              r_out_data  <= '0;
              r_out_err   <= 1'b0;
            end else if (cmd_num > NUM_WIDTH'(MAX_K)) begin
              r_state     <= ST_RESULT;
              r_out_valid <= 1'b1;
              r_out_data  <= '0;
              r_out_err   <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_in_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_wr_en && w_last_load) begin
            r_in_ready  <= 1'b0;
            r_num_valid <= 1'b1;
            r_num       <= r_k;
            r_state     <= ST_PROGRAM;
          end
        end
        ST_PROGRAM: begin
          r_num_valid <= 1'b0;
          r_data_a    <= w_rd_a;
          r_data_b    <= w_rd_b;
          r_state     <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_last_beat) begin
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_drain_cnt <= '0;
            r_state     <= ST_DRAIN;
          end else begin
            r_data_a <= w_rd_a;
            r_data_b <= w_rd_b;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == DC_W'(DRAIN_CYCLES - 1)) begin
            r_out_data  <= result_r;
            r_out_valid <= 1'b1;
            r_state     <= ST_RESULT;
          end else begin
            r_drain_cnt <= r_drain_cnt + DC_W'(1);
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign in_ready  = r_in_ready;
  assign num_valid = r_num_valid;
  assign num       = r_num;
  assign data_a    = r_data_a;
  assign data_b    = r_data_b;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

endmodule
